// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single banked line-memory port between the I-cache, D-cache and DMA.
// D wins I/D contention until I has been passed over STARVE_LIMIT times in a row.
module mem_arbiter #(
   parameter int LINE_BITS    = 64,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_readM,
   input  logic                 i_writeM,
   input  logic [15:0]          i_address,
   input  logic [LINE_BITS-1:0] i_wdata,
   output logic [LINE_BITS-1:0] i_rdata,
   output logic                 i_input_readyM,
   output logic                 i_doneM,
   input  logic                 d_readM,
   input  logic                 d_writeM,
   input  logic [15:0]          d_address,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 d_input_readyM,
   output logic                 d_doneM,
   input  logic                 dma_br,
   output logic                 dma_bg,
   input  logic                 dma_readM,
   input  logic                 dma_writeM,
   input  logic [15:0]          dma_address,
   input  logic [LINE_BITS-1:0] dma_wdata,
   output logic                 mem_readM,
   output logic                 mem_writeM,
   output logic [15:0]          mem_address,
   output logic [LINE_BITS-1:0] mem_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata,
   input  logic                 mem_readyM,
   input  logic                 mem_input_readyM,
   input  logic                 mem_doneM
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DMA} state_t;
   typedef enum logic [1:0] {NONE, OWN_I, OWN_D} owner_t;

   typedef struct packed {
      logic                 rd;
      logic                 wr;
      logic [15:0]          addr;
      logic [LINE_BITS-1:0] wdata;
   } req_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t     state;
   owner_t     owner;
   logic [2:0] starveCnt;
   req_t       memReq;
   req_t       iReq, dReq;
   logic       iPend, dPend, pickI;
   logic       inDma, iOwn, dOwn;

   // read+write together is a write
   assign iReq  = '{rd: i_readM & ~i_writeM, wr: i_writeM, addr: i_address, wdata: i_wdata};
   assign dReq  = '{rd: d_readM & ~d_writeM, wr: d_writeM, addr: d_address, wdata: d_wdata};
   assign iPend = i_readM | i_writeM;
   assign dPend = d_readM | d_writeM;
   assign pickI = iPend && (!dPend || starveCnt == LIMIT);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= NONE;
         starveCnt <= '0;
         memReq    <= '0;
         dma_bg    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dma_br) begin
                  state  <= DMA;
                  dma_bg <= 1'b1;
               end else if (iPend || dPend) begin
                  state <= ISSUE;
                  if (pickI) begin
                     owner     <= OWN_I;
                     memReq    <= iReq;
                     starveCnt <= '0;
                  end else begin
                     owner     <= OWN_D;
                     memReq    <= dReq;
                     starveCnt <= !iPend ? 3'd0 :
                                  (starveCnt == LIMIT) ? LIMIT : starveCnt + 3'd1;
                  end
               end
            end
            ISSUE: begin
               // address and data stay put; only the strobes drop once accepted
               if (mem_readyM) begin
                  state     <= WAIT;
                  memReq.rd <= 1'b0;
                  memReq.wr <= 1'b0;
               end
            end
            WAIT: begin
               if (mem_doneM) begin
                  state <= IDLE;
                  owner <= NONE;
               end
            end
            DMA: begin
               if (!dma_br) begin
                  state  <= IDLE;
                  dma_bg <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign inDma = (state == DMA);
   assign iOwn  = (state == WAIT) && (owner == OWN_I);
   assign dOwn  = (state == WAIT) && (owner == OWN_D);

   assign mem_readM   = inDma ? dma_readM   : memReq.rd;
   assign mem_writeM  = inDma ? dma_writeM  : memReq.wr;
   assign mem_address = inDma ? dma_address : memReq.addr;
   assign mem_wdata   = inDma ? dma_wdata   : memReq.wdata;

   assign i_rdata        = iOwn ? mem_rdata : '0;
   assign i_input_readyM = iOwn & mem_input_readyM;
   assign i_doneM        = iOwn & mem_doneM;
   assign d_rdata        = dOwn ? mem_rdata : '0;
   assign d_input_readyM = dOwn & mem_input_readyM;
   assign d_doneM        = dOwn & mem_doneM;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural line memory (4-edge latency) plus a transaction
// table and hand-written sequences for starvation, DMA hand-off, reset and contention.
module tb_mem_arbiter;
   localparam int LB = 64;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_readM = 0, i_writeM = 0, d_readM = 0, d_writeM = 0;
   logic [15:0]   i_address = '0, d_address = '0, dma_address = '0;
   logic [LB-1:0] i_wdata = '0, d_wdata = '0, dma_wdata = '0;
   logic [LB-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic          i_input_readyM, i_doneM, d_input_readyM, d_doneM;
   logic          dma_br = 0, dma_readM = 0, dma_writeM = 0, dma_bg;
   logic          mem_readM, mem_writeM, mem_readyM, mem_input_readyM, mem_doneM;
   logic [15:0]   mem_address;

   mem_arbiter #(.LINE_BITS(LB), .STARVE_LIMIT(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_input_readyM(i_input_readyM), .i_doneM(i_doneM),
      .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_input_readyM(d_input_readyM), .d_doneM(d_doneM),
      .dma_br(dma_br), .dma_bg(dma_bg), .dma_readM(dma_readM), .dma_writeM(dma_writeM),
      .dma_address(dma_address), .dma_wdata(dma_wdata),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_readyM(mem_readyM),
      .mem_input_readyM(mem_input_readyM), .mem_doneM(mem_doneM)
   );

   always #5 clk = ~clk;

   // memory model: accepts when idle, done 4 edges after acceptance
   logic [LB-1:0] memArr [int];
   logic          busy = 0, pWr = 0;
   logic [2:0]    lat = '0;
   logic [13:0]   pAddr = '0;
   logic [LB-1:0] mRdata = '0;
   logic          mDone = 0, mInRdy = 0;

   assign mem_readyM       = ~busy;
   assign mem_rdata        = mRdata;
   assign mem_doneM        = mDone;
   assign mem_input_readyM = mInRdy;

   always @(posedge clk) begin
      if (!reset_n) begin
         busy <= 0; lat <= '0; mDone <= 0; mInRdy <= 0; mRdata <= '0;
         memArr[9] = 64'hf41c_6200_6100_f01c;
      end else begin
         mDone <= 0; mInRdy <= 0;
         if (!busy && (mem_readM || mem_writeM)) begin
            busy <= 1; lat <= 3'd4; pWr <= mem_writeM; pAddr <= mem_address[15:2];
            if (mem_writeM) memArr[int'(mem_address[15:2])] = mem_wdata;
         end else if (busy) begin
            if (lat == 3'd1) begin
               busy <= 0; mDone <= 1;
               if (!pWr) begin
                  mInRdy <= 1;
                  mRdata <= memArr.exists(int'(pAddr)) ? memArr[int'(pAddr)] : '0;
               end
            end else lat <= lat - 3'd1;
         end
      end
   end

   logic [15:0] grantQ [$];
   int          dDoneCnt = 0;
   always @(posedge clk) begin
      if (reset_n && !dma_bg && mem_readyM && (mem_readM || mem_writeM)) grantQ.push_back(mem_address);
      if (d_doneM) dDoneCnt++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          isD, rd, wr;
      logic [15:0]   addr;
      logic [LB-1:0] wdata, expRd;
   } xact_t;

   task automatic drive(input xact_t t, input logic on);
      if (t.isD) begin
         d_readM = on & t.rd; d_writeM = on & t.wr; d_address = t.addr; d_wdata = t.wdata;
      end else begin
         i_readM = on & t.rd; i_writeM = on & t.wr; i_address = t.addr; i_wdata = t.wdata;
      end
   endtask

   task automatic doXact(input xact_t t, input string tag);
      logic seen, other, isRd;
      seen = 0; other = 0; isRd = t.rd & ~t.wr;
      drive(t, 1'b1);
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            chk({tag, " mem_readM"}, LB'(mem_readM), LB'(isRd));
            chk({tag, " mem_writeM"}, LB'(mem_writeM), LB'(t.wr));
            chk({tag, " mem_address"}, LB'(mem_address), LB'(t.addr));
            chk({tag, " mem_wdata"}, mem_wdata, t.wdata);
         end
         if (n == 2) chk({tag, " strobe drop"}, LB'(mem_readM | mem_writeM), '0);
         other |= t.isD ? (i_doneM | i_input_readyM | (|i_rdata))
                        : (d_doneM | d_input_readyM | (|d_rdata));
         if (t.isD ? d_doneM : i_doneM) begin
            seen = 1;
            chk({tag, " latency"}, LB'(n), LB'(6));
            chk({tag, " input_ready"}, LB'(t.isD ? d_input_readyM : i_input_readyM), LB'(isRd));
            if (isRd) chk({tag, " rdata"}, t.isD ? d_rdata : i_rdata, t.expRd);
            drive(t, 1'b0);
         end
      end
      chk({tag, " done seen"}, LB'(seen), LB'(1));
      chk({tag, " other side quiet"}, LB'(other), '0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      xact_t       tbl [8];
      xact_t       x;
      logic [15:0] expOrder [8];
      int          base, dBase;
      logic        bgEarly, seen;

      tbl[0] = '{0, 1, 0, 16'h0025, 64'h0, 64'hf41c_6200_6100_f01c};
      tbl[1] = '{1, 0, 1, 16'h01F4, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0};
      tbl[2] = '{1, 1, 0, 16'h01F4, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD};
      tbl[3] = '{0, 1, 0, 16'h01F6, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD};
      tbl[4] = '{1, 1, 1, 16'h0040, 64'h1234_5678_9ABC_DEF0, 64'h0};
      tbl[5] = '{1, 1, 0, 16'h0041, 64'h0, 64'h1234_5678_9ABC_DEF0};
      tbl[6] = '{0, 0, 1, 16'h0008, 64'h5555_6666_7777_8888, 64'h0};
      tbl[7] = '{0, 1, 0, 16'h000B, 64'h0, 64'h5555_6666_7777_8888};

      repeat (3) @(posedge clk);
      #1;
      chk("reset mem strobes", LB'(mem_readM | mem_writeM), '0);
      chk("reset mem_address", LB'(mem_address), '0);
      chk("reset mem_wdata", mem_wdata, '0);
      chk("reset dma_bg", LB'(dma_bg), '0);
      chk("reset rdata", i_rdata | d_rdata, '0);
      chk("reset pulses", LB'({i_doneM, i_input_readyM, d_doneM, d_input_readyM}), '0);
      reset_n = 1;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) doXact(tbl[k], $sformatf("xact%0d", k));

      // I and D held together: D,D,D,I repeating
      base = grantQ.size();
      i_readM = 1; i_address = 16'h0100; d_readM = 1; d_address = 16'h0200;
      for (int c = 0; c < 80 && grantQ.size() < base + 8; c++) begin @(posedge clk); #1; end
      i_readM = 0; d_readM = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("starve grant count", LB'(grantQ.size() - base), LB'(8));
      expOrder = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0100};
      for (int k = 0; k < 8; k++)
         if (grantQ.size() > base + k) chk($sformatf("starve grant %0d", k), LB'(grantQ[base + k]), LB'(expOrder[k]));

      // DMA requested mid I-read, D pending behind it
      i_readM = 1; i_address = 16'h0025; bgEarly = 0;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         if (c >= 3) bgEarly |= dma_bg;
         if (c == 3) begin dma_br = 1; d_readM = 1; d_address = 16'h0300; end
         if (c == 6) begin chk("dma: i read done", LB'(i_doneM), LB'(1)); i_readM = 0; end
      end
      chk("dma: grant held off", LB'(bgEarly), '0);
      @(posedge clk); #1;
      chk("dma: bg rises", LB'(dma_bg), LB'(1));
      chk("dma: D not issued", LB'(mem_readM), '0);
      dma_writeM = 1; dma_address = 16'h0300; dma_wdata = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("dma: write passthrough", LB'({mem_writeM, mem_address}), LB'({1'b1, 16'h0300}));
      chk("dma: wdata passthrough", mem_wdata, 64'h0123_4567_89AB_CDEF);
      @(posedge clk); #1;
      dma_writeM = 0; seen = 0; bgEarly = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         seen = mem_doneM;
         bgEarly |= d_doneM | i_doneM;
      end
      chk("dma: mem done", LB'(seen), LB'(1));
      chk("dma: no cache pulses", LB'(bgEarly), '0);
      dma_br = 0;
      @(posedge clk); #1;
      chk("dma: bg falls", LB'(dma_bg), '0);
      chk("dma: idle gap", LB'(mem_readM), '0);
      @(posedge clk); #1;
      chk("dma: D issues", LB'({mem_readM, mem_address}), LB'({1'b1, 16'h0300}));
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         if (d_doneM) begin
            seen = 1;
            chk("dma: D reads DMA line", d_rdata, 64'h0123_4567_89AB_CDEF);
            d_readM = 0;
         end
      end
      chk("dma: D done", LB'(seen), LB'(1));
      @(posedge clk); #1;

      // reset during WAIT of a D read
      d_readM = 1; d_address = 16'h01F4; d_wdata = 64'hFFFF_0000_FFFF_0000;
      for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
      reset_n = 0; d_readM = 0;
      @(posedge clk); #1;
      chk("midrst strobes", LB'(mem_readM | mem_writeM), '0);
      chk("midrst mem_address", LB'(mem_address), '0);
      chk("midrst mem_wdata", mem_wdata, '0);
      chk("midrst d outputs", LB'({d_doneM, d_input_readyM, |d_rdata, dma_bg}), '0);
      reset_n = 1;
      dBase = dDoneCnt;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst no stale done", LB'(dDoneCnt - dBase), '0);
      doXact(tbl[0], "postrst");

      // I, D and DMA all at once: DMA, then D, then I
      base = grantQ.size();
      i_readM = 1; i_address = 16'h0100;
      d_writeM = 1; d_address = 16'h0200; d_wdata = 64'hDEAD_BEEF_0000_1111;
      dma_br = 1;
      @(posedge clk); #1;
      chk("contend: dma first", LB'(dma_bg), LB'(1));
      dma_br = 0;
      for (int c = 0; c < 40 && (i_readM || d_writeM); c++) begin
         @(posedge clk); #1;
         if (d_doneM) d_writeM = 0;
         if (i_doneM) i_readM = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("contend grant count", LB'(grantQ.size() - base), LB'(2));
      if (grantQ.size() >= base + 2) begin
         chk("contend first D", LB'(grantQ[base]), LB'(16'h0200));
         chk("contend then I", LB'(grantQ[base + 1]), LB'(16'h0100));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
